// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment score path: active-low {g,f,e,d,c,b,a} digit patterns
// and the score decoder's FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_TENS = 2'd0,
    S_ONES = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational active-low 7-segment code to BCD digit decoder. Only exact patterns are legal;
// the all-off blank pattern is accepted as 0 when i_blank_ok is set.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic       i_blank_ok,
  output logic       o_legal,
  output logic [3:0] o_digit
);

  always_comb begin
    o_legal = 1'b1;
    o_digit = 4'd0;
    case (i_seg)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_legal = i_blank_ok;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_score_decoder.sv
// Assembles a binary score from a tens/ones pair of 7-segment codes over valid/ready streams.
// Define SEG_BLANK_EN to accept a blank tens digit as 0 (leading-zero suppression).
module seg7_score_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned MAX_SCORE = 31,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         seg_in,
  input  logic               seg_valid,
  output logic               seg_ready,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  input  logic               score_ready,
  output logic               err
);

`ifdef SEG_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  state_e             r_state, w_state_nxt;
  logic [3:0]         r_tens, w_tens_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic               r_score_valid, w_score_valid_nxt;
  logic               r_err, w_err_nxt;

  logic       w_blank_ok;
  logic       w_legal;
  logic [3:0] w_digit;
  logic [6:0] w_sum;
  logic       w_over;
  logic       w_xfer;

  // Blank is only ever acceptable in the tens slot.
  assign w_blank_ok = BlankEn && (r_state == S_TENS);

  seg7_digit_decode u_digit_decode (
    .i_seg      (seg_in),
    .i_blank_ok (w_blank_ok),
    .o_legal    (w_legal),
    .o_digit    (w_digit)
  );

  assign w_sum  = {3'b000, r_tens} * 7'd10 + {3'b000, w_digit};
  assign w_over = {25'd0, w_sum} > MAX_SCORE;

  // Registered-state decode only, so seg_ready never depends on score_ready.
  assign seg_ready = (r_state != S_OUT) && !reset;
  assign w_xfer    = seg_valid && seg_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_tens_nxt        = r_tens;
    w_score_nxt       = r_score;
    w_score_valid_nxt = r_score_valid;
    w_err_nxt         = 1'b0;
    case (r_state)
      S_TENS: begin
        if (w_xfer) begin
          if (w_legal) begin
            w_tens_nxt  = w_digit;
            w_state_nxt = S_ONES;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_ONES: begin
        if (w_xfer) begin
          if (!w_legal || w_over) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_TENS;
          end else begin
            w_score_nxt       = SCORE_W'(w_sum);
            w_score_valid_nxt = 1'b1;
            w_state_nxt       = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (score_ready) begin
          w_score_valid_nxt = 1'b0;
          w_state_nxt       = S_TENS;
        end
      end
      default: w_state_nxt = S_TENS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_TENS;
      r_tens        <= 4'd0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tens        <= w_tens_nxt;
      r_score       <= w_score_nxt;
      r_score_valid <= w_score_valid_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign score       = r_score;
  assign score_valid = r_score_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_score_decoder.sv
// Directed bench for seg7_score_decoder; expected values are hand-computed per vector.
// Blank-tens expectations follow SEG_BLANK_EN as compiled.
module tb_seg7_score_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic [7:0] score;
  logic       score_valid;
  logic       score_ready;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_score_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .score       (score),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .err         (err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one code, wait (bounded) for the transfer edge, then sample 1 time unit later.
  task automatic send(input logic [6:0] code);
    int n;
    n = 0;
    @(negedge clk);
    seg_in    = code;
    seg_valid = 1'b1;
    while (!seg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", int'(seg_ready), 1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    seg_in      = 7'd0;
    seg_valid   = 1'b0;
    score_ready = 1'b1;
    tick();
    tick();
    check("rst_score", int'(score), 0);
    check("rst_score_valid", int'(score_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_seg_ready", int'(seg_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_seg_ready", int'(seg_ready), 1);

    // 1: 2,1 -> 21
    send(7'b0100100);
    check("t1_tens_err", int'(err), 0);
    send(7'b1111001);
    check("t1_valid", int'(score_valid), 1);
    check("t1_score", int'(score), 21);
    check("t1_err", int'(err), 0);
    tick();
    check("t1_valid_drop", int'(score_valid), 0);
    check("t1_score_hold", int'(score), 21);

    // 2: 1,8 -> 18 held under backpressure, extra seg_valid ignored
    score_ready = 1'b0;
    send(7'b1111001);
    send(7'b0000000);
    check("t2_valid", int'(score_valid), 1);
    check("t2_score", int'(score), 18);
    seg_in    = 7'b0010010;
    seg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_seg_ready_low", int'(seg_ready), 0);
      tick();
      check("t2_score_held", int'(score), 18);
      check("t2_valid_held", int'(score_valid), 1);
      check("t2_no_err", int'(err), 0);
    end
    seg_valid   = 1'b0;
    score_ready = 1'b1;
    tick();
    check("t2_valid_drop", int'(score_valid), 0);
    check("t2_seg_ready_back", int'(seg_ready), 1);

    // 3: 3,2 -> 32 > 31, err and no score; then 8,0 -> 80 err; then 1,5 -> 15
    send(7'b0110000);
    send(7'b0100100);
    check("t3_err", int'(err), 1);
    check("t3_no_valid", int'(score_valid), 0);
    check("t3_score_unchanged", int'(score), 18);
    tick();
    check("t3_err_pulse_end", int'(err), 0);
    send(7'b0000000);
    check("t3_new_tens_no_err", int'(err), 0);
    send(7'b1000000);
    check("t3_80_err", int'(err), 1);
    check("t3_80_no_valid", int'(score_valid), 0);
    send(7'b1111001);
    send(7'b0010010);
    check("t3_15_valid", int'(score_valid), 1);
    check("t3_15_score", int'(score), 15);

    // 4: illegal tens, stay in tens; then 0,9 -> 9
    send(7'b0101010);
    check("t4_err", int'(err), 1);
    check("t4_seg_ready", int'(seg_ready), 1);
    send(7'b1000000);
    check("t4_tens_no_err", int'(err), 0);
    send(7'b0011000);
    check("t4_score", int'(score), 9);
    check("t4_valid", int'(score_valid), 1);

    // 5: blank tens + 7
    send(7'b1111111);
`ifdef SEG_BLANK_EN
    check("t5_blank_no_err", int'(err), 0);
    send(7'b1111000);
    check("t5_score", int'(score), 7);
    check("t5_valid", int'(score_valid), 1);
`else
    check("t5_blank_err", int'(err), 1);
    send(7'b1111000);
    check("t5_7_as_tens_no_err", int'(err), 0);
    check("t5_no_valid", int'(score_valid), 0);
    check("t5_score_unchanged", int'(score), 9);
`endif
    // Blank in ones position is always illegal.
    if (score_valid) tick();
`ifdef SEG_BLANK_EN
    send(7'b1111001);
`endif
    send(7'b1111111);
    check("t5_blank_ones_err", int'(err), 1);
    check("t5_blank_ones_no_valid", int'(score_valid), 0);

    // 6: reset after tens accepted discards it
    send(7'b0011001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_ready_in_reset", int'(seg_ready), 0);
    tick();
    check("t6_ready_in_reset2", int'(seg_ready), 0);
    check("t6_no_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
    send(7'b0100100);
    send(7'b1000000);
    check("t6_score", int'(score), 20);
    check("t6_valid", int'(score_valid), 1);
    check("t6_err", int'(err), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
